// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx -- fixed-baud UART transmitter.
//
// Serialises one PAYLOAD_BITS-wide word per accepted request as
//   start bit (0), data LSB first, [even parity], STOP_BITS stop bits (1).
// Bit timing matches the companion fixed-baud receiver, so a looped-back pin
// reproduces the transmitted word.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is inserted after the last data bit
//   undefined -> no parity state or parity logic
//
// Parameters:
//   CYCLES_PER_BIT  clk cycles per serial bit period (>= 2)
//   PAYLOAD_BITS    data bits per frame
//   STOP_BITS       stop bits per frame (1 or 2)
//   COUNT_REG_LEN   cycle counter width; must hold CYCLES_PER_BIT-1
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   resetn        in   synchronous active-low reset
//   uart_tx_en    in   send request, qualifies uart_tx_data
//   uart_tx_data  in   word to transmit, sampled only when accepted
//   uart_tx_busy  out  high while a frame is in progress (requests ignored)
//   uart_txd      out  registered UART transmit pin, idles high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int PAYLOAD_BITS   = 8,
  parameter int STOP_BITS      = 1,
  parameter int COUNT_REG_LEN  = 14
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy,
  output logic                    uart_txd
);

  localparam int BIT_CNT_LEN = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [COUNT_REG_LEN-1:0] LAST_CYCLE = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_CNT_LEN-1:0]   LAST_BIT   = BIT_CNT_LEN'(PAYLOAD_BITS - 1);
  localparam logic                     LAST_STOP  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state;
  logic [COUNT_REG_LEN-1:0] cycle_count;
  logic [BIT_CNT_LEN-1:0]   bit_count;
  logic                     stop_count;
  logic [PAYLOAD_BITS-1:0]  shift_reg;
  logic [PAYLOAD_BITS-1:0]  shift_next;
  logic                     next_bit;
`ifdef UART_TX_PARITY_EN
  logic                     parity_bit;
`endif

  // next_bit marks the last cycle of the current bit period; the pin is only
  // ever updated on that cycle (or on acceptance), so it never glitches.
  always_comb begin
    next_bit   = (cycle_count == LAST_CYCLE);
    shift_next = shift_reg >> 1;
  end

  // Single-process FSM: state, counters and both outputs are registered
  // together so busy always tracks (state != IDLE) exactly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cycle_count  <= '0;
      bit_count    <= '0;
      stop_count   <= 1'b0;
      shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else begin
      // Cycle counter runs in every non-IDLE state and wraps per bit period.
      if (state == IDLE || next_bit) begin
        cycle_count <= '0;
      end else begin
        cycle_count <= cycle_count + 1'b1;
      end

      case (state)
        IDLE: begin
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          bit_count    <= '0;
          stop_count   <= 1'b0;
          if (uart_tx_en) begin
            shift_reg    <= uart_tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit   <= ^uart_tx_data;
`endif
            state        <= START;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
          end
        end

        START: begin
          if (next_bit) begin
            state    <= SEND;
            uart_txd <= shift_reg[0];
          end
        end

        // The pin is loaded one bit ahead from shift_next, so the register
        // shift and the pin change land on the same bit boundary.
        SEND: begin
          if (next_bit) begin
            shift_reg <= shift_next;
            if (bit_count == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              uart_txd <= parity_bit;
`else
              state    <= STOP;
              uart_txd <= 1'b1;
`endif
            end else begin
              bit_count <= bit_count + 1'b1;
              uart_txd  <= shift_next[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (next_bit) begin
            state    <= STOP;
            uart_txd <= 1'b1;
          end
        end
`endif

        STOP: begin
          uart_txd <= 1'b1;
          if (next_bit) begin
            if (stop_count == LAST_STOP) begin
              state        <= IDLE;
              uart_tx_busy <= 1'b0;
            end else begin
              stop_count <= 1'b1;
            end
          end
        end

        default: begin
          state        <= IDLE;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two instances share clock, reset and data: dut1 with STOP_BITS=1 and dut2
// with STOP_BITS=2, both at CYCLES_PER_BIT=16. The expected pin level for
// every cycle of a frame comes from a frame-position model: cycle index /
// CYCLES_PER_BIT selects start, data bit, parity or stop.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 16;
  localparam int PB  = 8;
  localparam int BIG = 100000;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       en1    = 1'b0;
  logic       en2    = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       busy1, txd1, busy2, txd2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.CYCLES_PER_BIT(CPB), .PAYLOAD_BITS(PB), .STOP_BITS(1), .COUNT_REG_LEN(14)) dut1 (
    .clk(clk), .resetn(resetn), .uart_tx_en(en1), .uart_tx_data(data),
    .uart_tx_busy(busy1), .uart_txd(txd1)
  );

  uart_tx #(.CYCLES_PER_BIT(CPB), .PAYLOAD_BITS(PB), .STOP_BITS(2), .COUNT_REG_LEN(14)) dut2 (
    .clk(clk), .resetn(resetn), .uart_tx_en(en2), .uart_tx_data(data),
    .uart_tx_busy(busy2), .uart_txd(txd2)
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  // Expected line level at cycle idx of a frame (idx 0 = first start cycle).
  function automatic logic frameBit(input logic [7:0] d, input logic par, input int idx);
    int b;
    b = idx / CPB;
    if (b == 0) return 1'b0;
    if (b <= PB) return d[b-1];
    if (P == 1 && b == PB + 1) return par;
    return 1'b1;
  endfunction

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic applyStimulus(input logic [7:0] d, input bit onDut2, input bit hold);
    @(negedge clk);
    data = d;
    if (onDut2) en2 = 1'b1;
    else        en1 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      en1 = 1'b0;
      en2 = 1'b0;
    end
  endtask

  // Check up to 'cycles' cycles of a frame; optionally pulse a request mid-frame.
  task automatic checkFrame(input string name, input logic [7:0] d, input logic par,
                            input int stopBits, input bit onDut2, input int cycles,
                            input int pulseAt, input logic [7:0] pulseData);
    int   len;
    logic txd, busy;
    len = (1 + PB + P + stopBits) * CPB;
    for (int idx = 0; idx < cycles && idx < len; idx++) begin
      @(negedge clk);
      txd  = onDut2 ? txd2 : txd1;
      busy = onDut2 ? busy2 : busy1;
      checkOutput({name, " txd"}, txd, frameBit(d, par, idx));
      checkOutput({name, " busy"}, busy, 1'b1);
      if (pulseAt >= 0 && idx == pulseAt) begin
        data = pulseData;
        if (onDut2) en2 = 1'b1;
        else        en1 = 1'b1;
      end else if (pulseAt >= 0 && idx == pulseAt + 1) begin
        en1 = 1'b0;
        en2 = 1'b0;
      end
    end
  endtask

  task automatic checkIdle(input string name, input bit onDut2, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput({name, " txd"},  onDut2 ? txd2 : txd1,   1'b1);
      checkOutput({name, " busy"}, onDut2 ? busy2 : busy1, 1'b0);
    end
  endtask

  initial begin
    vec_t       vecs [9];
    logic [7:0] r;

    // Hand-derived even parity of each word.
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h81, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h7F, 1'b1};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h3C, 1'b0};
    vecs[8] = '{8'h12, 1'b0};

    // Reset held for 3 cycles, then a quiet line for 100 cycles.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset txd1", txd1, 1'b1);
    checkOutput("reset busy1", busy1, 1'b0);
    checkOutput("reset txd2", txd2, 1'b1);
    checkOutput("reset busy2", busy2, 1'b0);
    resetn = 1'b1;
    checkIdle("quiet", 1'b0, 100);
    checkIdle("quiet2", 1'b1, 4);

    // Table-driven frames on the single-stop instance.
    $display("[TB] table frames");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].data, 1'b0, 1'b0);
      checkFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, 1, 1'b0, BIG, -1, 8'h00);
      checkIdle($sformatf("vec%0d end", i), 1'b0, 2);
    end

    // Back-to-back: request held high; data changes right after acceptance.
    $display("[TB] back-to-back");
    applyStimulus(8'h00, 1'b0, 1'b1);
    data = 8'hFF;
    checkFrame("b2b first", 8'h00, 1'b0, 1, 1'b0, BIG, -1, 8'h00);
    checkIdle("b2b gap", 1'b0, 1);
    @(posedge clk);
    #1;
    en1 = 1'b0;
    checkFrame("b2b second", 8'hFF, 1'b0, 1, 1'b0, BIG, -1, 8'h00);
    checkIdle("b2b end", 1'b0, 3);

    // Request pulsed mid-frame must be dropped, not queued.
    $display("[TB] request during busy");
    applyStimulus(8'h81, 1'b0, 1'b0);
    checkFrame("busy ignore", 8'h81, 1'b0, 1, 1'b0, BIG, 50, 8'h3C);
    checkIdle("busy ignore end", 1'b0, 40);

    // Reset in data bit 4 of 0x55 aborts at the next edge.
    $display("[TB] reset mid-frame");
    applyStimulus(8'h55, 1'b0, 1'b0);
    checkFrame("abort", 8'h55, 1'b0, 1, 1'b0, 5 * CPB + 7, -1, 8'h00);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("abort txd", txd1, 1'b1);
    checkOutput("abort busy", busy1, 1'b0);
    resetn = 1'b1;
    checkIdle("abort idle", 1'b0, 5);
    applyStimulus(8'h12, 1'b0, 1'b0);
    checkFrame("after abort", 8'h12, 1'b0, 1, 1'b0, BIG, -1, 8'h00);
    checkIdle("after abort end", 1'b0, 2);

    // Two stop bits: stop level lasts 32 cycles before busy falls.
    $display("[TB] two stop bits");
    applyStimulus(8'h0F, 1'b1, 1'b0);
    checkFrame("stop2", 8'h0F, 1'b0, 2, 1'b1, BIG, -1, 8'h00);
    checkIdle("stop2 end", 1'b1, 3);

    // Randomised words against the frame model.
    $display("[TB] random frames");
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom_range(0, 255));
      applyStimulus(r, (i % 4) == 3, 1'b0);
      checkFrame($sformatf("rand%0d", i), r, ^r, ((i % 4) == 3) ? 2 : 1, (i % 4) == 3, BIG, -1, 8'h00);
      checkIdle($sformatf("rand%0d end", i), (i % 4) == 3, 1 + (i % 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
